// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Results are computed on acceptance and committed after a modelled latency.
module e_mdu #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam int unsigned PW         = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [WIDTH-1:0]  p_hi, p_hi_d;
    logic [WIDTH-1:0]  p_lo, p_lo_d;
    logic              p_skip, p_skip_d;
    logic              busy_d;
    logic [WIDTH-1:0]  hi_d, lo_d;

    logic              is_mul, is_div, is_signed;
    logic [PW-1:0]     mul_a, mul_b, prod;
    logic [WIDTH-1:0]  abs_a, abs_b, dvs, quo_u, rem_u, quo, rem;
    logic              div_zero, q_neg, r_neg;

    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);

    assign stall = busy | (start & (is_mul | is_div));

    // Sign-extending to the full product width makes one multiplier serve both forms.
    always_comb begin
        mul_a = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {WIDTH'(0), a};
        mul_b = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {WIDTH'(0), b};
        prod  = mul_a * mul_b;
    end

    // Signed divide runs on magnitudes; the quotient truncates toward zero and the
    // remainder takes the dividend's sign. Most-negative / -1 falls out naturally.
    always_comb begin
        div_zero = (b == '0);
        abs_a    = (is_signed && a[WIDTH-1]) ? WIDTH'(WIDTH'(0) - a) : a;
        abs_b    = (is_signed && b[WIDTH-1]) ? WIDTH'(WIDTH'(0) - b) : b;
        dvs      = div_zero ? WIDTH'(1) : abs_b;
        quo_u    = abs_a / dvs;
        rem_u    = abs_a % dvs;
        q_neg    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg    = is_signed && a[WIDTH-1];
        quo      = q_neg ? WIDTH'(WIDTH'(0) - quo_u) : quo_u;
        rem      = r_neg ? WIDTH'(WIDTH'(0) - rem_u) : rem_u;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            p_skip <= 1'b0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            p_hi   <= p_hi_d;
            p_lo   <= p_lo_d;
            p_skip <= p_skip_d;
            busy   <= busy_d;
            hi     <= hi_d;
            lo     <= lo_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        p_hi_d   = p_hi;
        p_lo_d   = p_lo;
        p_skip_d = p_skip;
        busy_d   = busy;
        hi_d     = hi;
        lo_d     = lo;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(MULT_CYCLES);
                        p_hi_d   = prod[PW-1:WIDTH];
                        p_lo_d   = prod[WIDTH-1:0];
                        p_skip_d = 1'b0;
                        busy_d   = 1'b1;
                    end else if (is_div) begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(DIV_CYCLES);
                        p_hi_d   = rem;
                        p_lo_d   = quo;
                        p_skip_d = div_zero;
                        busy_d   = 1'b1;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_RUN: begin
                cnt_d = CW'(cnt - CW'(1));
                if (cnt == CW'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (!p_skip) begin
                        hi_d = p_hi;
                        lo_d = p_lo;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
